// File: rtl/aes_cbc_chain_ctrl_if.sv
// Plaintext/ciphertext streams, message control and AES-core drive for aes_cbc_chain_ctrl.
// slave = controller side, master = environment (source, sink and the combinational core).
interface aes_cbc_chain_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic [127:0]     iv_in;
    logic [127:0]     key_in;

    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_data;
    logic             in_last;

    logic [127:0]     core_in;
    logic [127:0]     core_iv;
    logic [127:0]     core_key;
    logic [127:0]     core_out;

    logic             out_valid;
    logic             out_ready;
    logic [127:0]     out_data;
    logic             out_last;

    logic             busy;
    logic [CNT_W-1:0] blk_cnt;

    modport slave (
        input  start, iv_in, key_in,
        input  in_valid, in_data, in_last,
        input  core_out,
        input  out_ready,
        output in_ready,
        output core_in, core_iv, core_key,
        output out_valid, out_data, out_last,
        output busy, blk_cnt
    );

    modport master (
        output start, iv_in, key_in,
        output in_valid, in_data, in_last,
        output core_out,
        output out_ready,
        input  in_ready,
        input  core_in, core_iv, core_key,
        input  out_valid, out_data, out_last,
        input  busy, blk_cnt
    );
endinterface

// File: rtl/aes_cbc_chain_ctrl.sv
// CBC chaining controller in front of a combinational AES-128 core; one block in flight.
// Optional macro AES_CBC_ABORT_EN adds an abort input that drops the current message.
module aes_cbc_chain_ctrl #(
    parameter int CORE_LATENCY = 2,   // legal 1..15
    parameter int CNT_W        = 16
) (
    input logic clk,
    input logic rst,
`ifdef AES_CBC_ABORT_EN
    input logic abort,
`endif
    aes_cbc_chain_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_BLK = 2'd1,
        RUN      = 2'd2,
        HOLD     = 2'd3
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(CORE_LATENCY);

    state_t             state_q,    state_d;
    logic [127:0]       chain_q,    chain_d;
    logic [127:0]       key_q,      key_d;
    logic [127:0]       pt_q,       pt_d;
    logic               last_q,     last_d;
    logic [3:0]         cnt_q,      cnt_d;
    logic [127:0]       out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic               out_valid_q, out_valid_d;
    logic [CNT_W-1:0]   blk_cnt_q,  blk_cnt_d;

    always_comb begin
        state_d     = state_q;
        chain_d     = chain_q;
        key_d       = key_q;
        pt_d        = pt_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        blk_cnt_d   = blk_cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    chain_d   = bus.iv_in;
                    key_d     = bus.key_in;
                    blk_cnt_d = '0;
                    state_d   = WAIT_BLK;
                end
            end
            WAIT_BLK: begin
                // in_ready is high throughout this state, so in_valid alone completes the handshake
                if (bus.in_valid) begin
                    pt_d    = bus.in_data;
                    last_d  = bus.in_last;
                    cnt_d   = CNT_INIT;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == 4'd1) begin
                    out_data_d  = bus.core_out;
                    chain_d     = bus.core_out;
                    out_last_d  = last_q;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    blk_cnt_d   = blk_cnt_q + CNT_W'(1);
                    state_d     = out_last_q ? IDLE : WAIT_BLK;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef AES_CBC_ABORT_EN
        // Abort overrides everything above; chaining value and key survive for inspection.
        if (abort) begin
            state_d     = IDLE;
            chain_d     = chain_q;
            key_d       = key_q;
            pt_d        = pt_q;
            last_d      = last_q;
            cnt_d       = cnt_q;
            out_data_d  = out_data_q;
            out_last_d  = 1'b0;
            out_valid_d = 1'b0;
            blk_cnt_d   = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            chain_q     <= '0;
            key_q       <= '0;
            pt_q        <= '0;
            last_q      <= 1'b0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            blk_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            chain_q     <= chain_d;
            key_q       <= key_d;
            pt_q        <= pt_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            blk_cnt_q   <= blk_cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == WAIT_BLK);
    assign bus.busy      = (state_q != IDLE);
    assign bus.core_in   = pt_q;
    assign bus.core_iv   = chain_q;
    assign bus.core_key  = key_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.blk_cnt   = blk_cnt_q;

endmodule

// File: tb/tb_aes_cbc_chain_ctrl.sv
// Bench for aes_cbc_chain_ctrl: behavioural AES-128 core, NIST CBC table, corner sequences, random messages.
module tb_aes_cbc_chain_ctrl;

    localparam int LAT    = 3;
    localparam int BUDGET = 64;

    localparam logic [127:0] NIST_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] NIST_IV  = 128'h000102030405060708090a0b0c0d0e0f;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_cbc_chain_ctrl_if #(.CNT_W(16)) bus ();

`ifdef AES_CBC_ABORT_EN
    logic abort = 1'b0;
`endif

    aes_cbc_chain_ctrl #(.CORE_LATENCY(LAT), .CNT_W(16)) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef AES_CBC_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [127:0] cur_key;

    // ---------------- AES-128 reference (FIPS-197) ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rol8(input logic [7:0] x, input int k);
        return (x << k) | (x >> (8 - k));
    endfunction

    // S-box: multiplicative inverse (a^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq  = a;
        logic [7:0] inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [7:0]   st [16];
        logic [7:0]   tm [16];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int row = 0; row < 4; row++)
                for (int c = 0; c < 4; c++)
                    tm[row+4*c] = sbox(st[row + 4*((c+row)%4)]);
            for (int c = 0; c < 4; c++) begin
                a0 = tm[4*c]; a1 = tm[4*c+1]; a2 = tm[4*c+2]; a3 = tm[4*c+3];
                if (r < 10) begin
                    st[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    st[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    st[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    st[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    st[4*c] = a0; st[4*c+1] = a1; st[4*c+2] = a2; st[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
        return res;
    endfunction

    // Combinational core model, as aes_enc_top would behave.
    assign bus.core_out = aes_enc(bus.core_in ^ bus.core_iv, bus.core_key);

    // ---------------- helpers ----------------
    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [127:0] iv, input logic [127:0] key);
        bus.start  = 1'b1;
        bus.iv_in  = iv;
        bus.key_in = key;
        step();
        bus.start  = 1'b0;
        cur_key    = key;
        chk("busy_after_start", 128'(bus.busy), 128'(1));
    endtask

    // Present a block, confirm acceptance and core drive, then count edges until out_valid.
    task automatic send_blk(input logic [127:0] pt, input logic last, input logic [127:0] exp_chain);
        int n;
        bit ir_ok;
        n = 0;
        ir_ok = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = pt;
        bus.in_last  = last;
        while (!bus.in_ready && n < BUDGET) begin
            step();
            n++;
        end
        chk("in_ready_wait", 128'(bus.in_ready), 128'(1));
        step();
        bus.in_valid = 1'b0;
        bus.in_data  = ~pt;
        bus.in_last  = ~last;
        chk("core_in", bus.core_in, pt);
        chk("core_iv", bus.core_iv, exp_chain);
        chk("core_key", bus.core_key, cur_key);
        n = 0;
        while (!bus.out_valid && n < BUDGET) begin
            if (bus.in_ready) ir_ok = 1'b0;
            step();
            n++;
        end
        chk("latency", 128'(n), 128'(LAT));
        chk("in_ready_run", 128'(ir_ok), 128'(1));
    endtask

    // Hold out_ready low for 'stall' cycles (optionally poking start), then complete the handshake.
    task automatic finish_blk(input logic [127:0] exp_ct, input logic last, input int stall,
                              input bit poke, input int exp_cnt);
        bit ok;
        ok = 1'b1;
        bus.out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_ct ||
                bus.out_last !== last || bus.in_ready !== 1'b0) ok = 1'b0;
            if (poke && s == 2) begin
                bus.start  = 1'b1;
                bus.iv_in  = '0;
                bus.key_in = '0;
            end
            step();
            bus.start = 1'b0;
        end
        if (stall > 0) chk("hold_stable", 128'(ok), 128'(1));
        chk("out_valid", 128'(bus.out_valid), 128'(1));
        chk("out_data", bus.out_data, exp_ct);
        chk("out_last", 128'(bus.out_last), 128'(last));
        chk("in_ready_hold", 128'(bus.in_ready), 128'(0));
        $display("blk ct=%h last=%0b stall=%0d cnt=%0d", bus.out_data, bus.out_last, stall, exp_cnt);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("blk_cnt", 128'(bus.blk_cnt), 128'(exp_cnt));
        chk("out_valid_drop", 128'(bus.out_valid), 128'(0));
        chk("busy_after_blk", 128'(bus.busy), 128'(!last));
    endtask

    typedef struct {
        logic [127:0] pt;
        logic         last;
        logic [127:0] ct;
        int           stall;
        bit           poke;
    } vec_t;

    vec_t nist [4];

    task automatic run_nist(input bit with_bp);
        logic [127:0] chain;
        do_start(NIST_IV, NIST_KEY);
        chain = NIST_IV;
        for (int i = 0; i < 4; i++) begin
            send_blk(nist[i].pt, nist[i].last, chain);
            finish_blk(nist[i].ct, nist[i].last, with_bp ? nist[i].stall : 0,
                       with_bp && nist[i].poke, i + 1);
            chain = nist[i].ct;
        end
        chk("nist_blk_cnt", 128'(bus.blk_cnt), 128'(4));
        chk("nist_idle", 128'(bus.busy), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] iv, key, pt, prev, ct;
        int len;

        nist[0] = '{128'h6bc1bee22e409f96e93d7e117393172a, 1'b0, 128'h7649abac8119b246cee98e9b12e9197d, 0,  1'b0};
        nist[1] = '{128'hae2d8a571e03ac9c9eb76fac45af8e51, 1'b0, 128'h5086cb9b507219ee95db113a917678b2, 10, 1'b1};
        nist[2] = '{128'h30c81c46a35ce411e5fbc1191a0a52ef, 1'b0, 128'h73bed6b8e3c1743b7116e69e22229516, 2,  1'b0};
        nist[3] = '{128'hf69f2445df4f9b17ad2b417be66c3710, 1'b1, 128'h3ff1caa1681fac09120eca307586e1a7, 0,  1'b0};

        bus.start = 1'b0; bus.iv_in = '0; bus.key_in = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
        bus.out_ready = 1'b0;
        cur_key = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 128'(bus.in_ready), 128'(0));
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_out_last", 128'(bus.out_last), 128'(0));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_blk_cnt", 128'(bus.blk_cnt), 128'(0));
        chk("rst_out_data", bus.out_data, 128'(0));
        chk("rst_core_iv", bus.core_iv, 128'(0));
        chk("rst_core_key", bus.core_key, 128'(0));
        rst = 1'b0;
        step();
        chk("idle_in_ready", 128'(bus.in_ready), 128'(0));

        // NIST vector with backpressure on block 2 and an ignored start pulse during it
        run_nist(1'b1);

        // Reset while a block is in RUN, then rerun the vector
        do_start(NIST_IV, NIST_KEY);
        send_blk(nist[0].pt, 1'b0, NIST_IV);
        // send_blk returns in HOLD; start a fresh block to catch RUN
        finish_blk(nist[0].ct, 1'b0, 0, 1'b0, 1);
        bus.in_valid = 1'b1; bus.in_data = nist[1].pt; bus.in_last = 1'b0;
        step();
        bus.in_valid = 1'b0;
        step();
        chk("mid_run_busy", 128'(bus.busy), 128'(1));
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("arst_busy", 128'(bus.busy), 128'(0));
        chk("arst_blk_cnt", 128'(bus.blk_cnt), 128'(0));
        chk("arst_core_in", bus.core_in, 128'(0));
        chk("arst_core_iv", bus.core_iv, 128'(0));
        chk("arst_core_key", bus.core_key, 128'(0));
        chk("arst_out_data", bus.out_data, 128'(0));
        step();
        rst = 1'b0;
        step();
        run_nist(1'b0);

        // Random messages against the CBC model: c_i = E_k(p_i ^ c_{i-1}), c_0 = iv
        for (int m = 0; m < 12; m++) begin
            iv   = rand128();
            key  = rand128();
            len  = $urandom_range(1, 4);
            do_start(iv, key);
            prev = iv;
            for (int b = 0; b < len; b++) begin
                pt = rand128();
                ct = aes_enc(pt ^ prev, key);
                send_blk(pt, b == len - 1, prev);
                finish_blk(ct, b == len - 1, $urandom_range(0, 3), 1'b0, b + 1);
                prev = ct;
            end
            repeat ($urandom_range(0, 2)) step();
        end

`ifdef AES_CBC_ABORT_EN
        // Abort in HOLD of block 2, colliding with a start pulse
        do_start(NIST_IV, NIST_KEY);
        send_blk(nist[0].pt, 1'b0, NIST_IV);
        finish_blk(nist[0].ct, 1'b0, 0, 1'b0, 1);
        send_blk(nist[1].pt, 1'b0, nist[0].ct);
        abort = 1'b1;
        bus.start = 1'b1; bus.iv_in = '0; bus.key_in = '0;
        step();
        abort = 1'b0;
        bus.start = 1'b0;
        chk("abort_out_valid", 128'(bus.out_valid), 128'(0));
        chk("abort_out_last", 128'(bus.out_last), 128'(0));
        chk("abort_busy", 128'(bus.busy), 128'(0));
        chk("abort_blk_cnt", 128'(bus.blk_cnt), 128'(0));
        chk("abort_chain_kept", bus.core_iv, nist[1].ct);
        chk("abort_key_kept", bus.core_key, NIST_KEY);
        do_start(NIST_IV, NIST_KEY);
        send_blk(nist[0].pt, 1'b1, NIST_IV);
        finish_blk(nist[0].ct, 1'b1, 0, 1'b0, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_cbc_chain_ctrl.md
Name: aes_cbc_chain_ctrl

Overview:
Sequential CBC chaining controller that sits directly upstream of the combinational AES-128 encryption core aes_enc_top. It accepts plaintext blocks over a valid/ready stream and drives the core's in/iv/key inputs. It waits a fixed settle time, captures the core output as ciphertext, and feeds that ciphertext back as the next block's IV. Ciphertext leaves on a valid/ready stream with message framing.

Parameters:
CORE_LATENCY, 2, cycles core inputs are held stable before core_out is sampled; legal 1..15.
CNT_W, 16, width of the blocks-emitted counter blk_cnt.

Ports:
clk  input  1  system clock, all flops rising-edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; latches iv_in/key_in and begins a message (honoured only in IDLE)
iv_in  input  128  initial IV for the message
key_in  input  128  AES-128 key for the message
in_valid  input  1  plaintext block valid
in_ready  output  1  controller can accept a plaintext block
in_data  input  128  plaintext block
in_last  input  1  final block of the message, qualified by in_valid
core_in  output  128  to aes_enc_top.in (registered plaintext)
core_iv  output  128  to aes_enc_top.iv (chaining register)
core_key  output  128  to aes_enc_top.key (registered key)
core_out  input  128  from aes_enc_top.out (ciphertext)
out_valid  output  1  ciphertext valid
out_ready  input  1  downstream accepts ciphertext
out_data  output  128  ciphertext block
out_last  output  1  final ciphertext of the message
busy  output  1  high in any state except IDLE
blk_cnt  output  CNT_W  ciphertext blocks accepted downstream in current message

Behaviour:
- Reset (async, rst=1): state IDLE; in_ready=0, out_valid=0, out_last=0, busy=0, blk_cnt=0; out_data, core_in, core_iv, core_key and the settle counter all cleared to 0.
- States: IDLE, WAIT_BLK, RUN, HOLD.
- IDLE: in_ready=0. start=1 -> chain_reg<=iv_in, key_reg<=key_in, blk_cnt<=0, go WAIT_BLK.
- WAIT_BLK: in_ready=1 (combinational from state only). On in_valid&&in_ready: pt_reg<=in_data, last_reg<=in_last, cnt<=CORE_LATENCY, go RUN.
- RUN: in_ready=0. If cnt==1: out_data<=core_out, chain_reg<=core_out, out_last<=last_reg, out_valid<=1, go HOLD; else cnt<=cnt-1.
- HOLD: out_valid=1; out_data and out_last stable until out_ready=1. On out_valid&&out_ready: out_valid<=0, blk_cnt<=blk_cnt+1 (wraps modulo 2^CNT_W), go IDLE if out_last else WAIT_BLK.
- Core drive: core_in=pt_reg, core_iv=chain_reg, core_key=key_reg, all registered; they do not change during RUN/HOLD.
- Latency: the edge accepting a block is E0; out_valid rises after edge E(CORE_LATENCY). With no backpressure, throughput is one block per CORE_LATENCY+2 cycles.
- One block in flight at a time; no input buffering.
- start while busy is ignored; iv/key are unchanged.
- in_last on the first block gives a one-block message.
- out_ready held low stalls indefinitely in HOLD with outputs stable.
- Reset asserted mid-operation returns to the reset values immediately; the in-flight block is lost.

Optional Feature:
Macro AES_CBC_ABORT_EN.
- Defined: adds input port abort (1 bit). abort=1 in any state forces IDLE at the next edge, with out_valid<=0, out_last<=0 and blk_cnt<=0; chain_reg and key_reg are retained. abort has priority over start and over all handshakes in the same cycle.
- Not defined: the port is absent; only rst terminates a message.

Test Plan:
- NIST CBC-AES128: key 2b7e151628aed2a6abf7158809cf4f3c, iv 000102030405060708090a0b0c0d0e0f, blocks 6bc1bee2...172a, ae2d8a57...8e51, 30c81c46...52ef, f69f2445...3710 (last on the 4th) -> out_data 7649abac8119b246cee98e9b12e9197d, 5086cb9b507219ee95db113a917678b2, 73bed6b8e3c1743b7116e69e22229516, 3ff1caa1681fac09120eca307586e1a7; out_last only on the 4th; blk_cnt=4; then IDLE.
- Chaining check: after block 1 is accepted, core_iv=7649abac8119b246cee98e9b12e9197d while block 2 is in RUN.
- Backpressure: out_ready=0 for 10 cycles on block 2 -> out_valid stays 1, out_data stays 5086cb9b...78b2, in_ready=0; release -> result identical to the unstalled run.
- Latency: CORE_LATENCY=3 -> out_valid rises exactly 3 edges after the in handshake; in_ready=0 throughout RUN/HOLD.
- start pulse during block 2 with iv_in=0 -> ignored, block 3 still 73bed6b8...9516; rst pulse in RUN -> all outputs 0, busy=0, and the next start re-runs vector 1 correctly.
- With AES_CBC_ABORT_EN: abort in HOLD of block 2 -> out_valid=0 next cycle, IDLE, blk_cnt=0; a new start with the NIST iv gives 7649abac...197d.
